// File: rtl/krnl_cbc_ap_sequencer_if.sv
// Control/command bundle between the ap_ctrl_chain slave, the DMA engines and the sequencer.
// master = sequencer side, slave = control slave plus DMA engines.
interface krnl_cbc_ap_sequencer_if;
    logic        ap_start;
    logic        ap_continue;
    logic        ap_ready;
    logic        ap_done;
    logic        ap_idle;
    logic        cbc_mode;
    logic [63:0] src_addr;
    logic [63:0] dest_addr;
    logic [31:0] words_num;
    logic        rd_cmd_valid;
    logic        rd_cmd_ready;
    logic [63:0] rd_cmd_addr;
    logic [31:0] rd_cmd_len;
    logic        wr_cmd_valid;
    logic        wr_cmd_ready;
    logic [63:0] wr_cmd_addr;
    logic [31:0] wr_cmd_len;
    logic        wr_done;
    logic        err_unexp;

    modport master (
        input  ap_start, ap_continue, cbc_mode, src_addr, dest_addr, words_num,
               rd_cmd_ready, wr_cmd_ready, wr_done,
        output ap_ready, ap_done, ap_idle,
               rd_cmd_valid, rd_cmd_addr, rd_cmd_len,
               wr_cmd_valid, wr_cmd_addr, wr_cmd_len, err_unexp
    );

    modport slave (
        output ap_start, ap_continue, cbc_mode, src_addr, dest_addr, words_num,
               rd_cmd_ready, wr_cmd_ready, wr_done,
        input  ap_ready, ap_done, ap_idle,
               rd_cmd_valid, rd_cmd_addr, rd_cmd_len,
               wr_cmd_valid, wr_cmd_addr, wr_cmd_len, err_unexp
    );
endinterface

// File: rtl/krnl_cbc_ap_sequencer.sv
// ap_ctrl_chain job sequencer: splits a job into paired rd/wr burst commands with an outstanding limit.
// Optional KRNL_CBC_SEQ_SERIAL_EN: cbc_mode sampled at ap_start forces one outstanding burst.
module krnl_cbc_ap_sequencer #(
    parameter int unsigned BURST_WORDS     = 64,
    parameter int unsigned WORD_BYTES      = 16,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    krnl_cbc_ap_sequencer_if.master     bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [31:0] BURST_LEN    = 32'(BURST_WORDS);
    localparam logic [3:0]  MAX_OUT      = 4'(MAX_OUTSTANDING);
    localparam logic [63:0] STRIDE_BYTES = 64'(WORD_BYTES);

    state_t      state_q;
    state_t      state_d;

    logic [63:0] rd_addr_q;
    logic [63:0] wr_addr_q;
    logic [31:0] remaining_q;
    logic [3:0]  outstanding_q;
    logic [3:0]  limit_q;
    logic        rd_vld_q;
    logic        wr_vld_q;
    logic        rd_got_q;
    logic        wr_got_q;
    logic        burst_act_q;
    logic        ap_ready_q;
    logic        err_q;

    logic [31:0] burst_len;
    logic [63:0] byte_step;
    logic        rd_hs;
    logic        wr_hs;
    logic        burst_issue;
    logic        last_issue;
    logic        launch;
    logic        accept;
    logic        done_ok;
    logic        stray_done;
    logic        idle;
    logic        done;

`ifndef KRNL_CBC_SEQ_SERIAL_EN
    logic        unused_cbc_mode;
    assign unused_cbc_mode = bus.cbc_mode;
`endif

    // Burst length and addresses only move on issue, so cmd fields stay stable while valid.
    always_comb begin
        burst_len   = (remaining_q < BURST_LEN) ? remaining_q : BURST_LEN;
        byte_step   = 64'(burst_len) * STRIDE_BYTES;
        rd_hs       = rd_vld_q & bus.rd_cmd_ready;
        wr_hs       = wr_vld_q & bus.wr_cmd_ready;
        burst_issue = burst_act_q & (rd_got_q | rd_hs) & (wr_got_q | wr_hs);
        last_issue  = burst_issue & (remaining_q == burst_len);
        launch      = (state_q == S_ISSUE) & ~burst_act_q & (remaining_q != '0)
                      & (outstanding_q < limit_q);
        accept      = (state_q == S_IDLE) & bus.ap_start;
        done_ok     = bus.wr_done & (outstanding_q != '0);
        stray_done  = bus.wr_done & (outstanding_q == '0);
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.ap_start) begin
                    state_d = (bus.words_num == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (last_issue) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (outstanding_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.ap_continue) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        idle = 1'b0;
        done = 1'b0;
        unique case (state_q)
            S_IDLE:  idle = 1'b1;
            S_DONE:  done = 1'b1;
            default: begin
                idle = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rd_addr_q     <= '0;
            wr_addr_q     <= '0;
            remaining_q   <= '0;
            outstanding_q <= '0;
            limit_q       <= MAX_OUT;
            rd_vld_q      <= 1'b0;
            wr_vld_q      <= 1'b0;
            rd_got_q      <= 1'b0;
            wr_got_q      <= 1'b0;
            burst_act_q   <= 1'b0;
            ap_ready_q    <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            ap_ready_q <= accept;

            if (accept) begin
                rd_addr_q   <= bus.src_addr;
                wr_addr_q   <= bus.dest_addr;
                remaining_q <= bus.words_num;
`ifdef KRNL_CBC_SEQ_SERIAL_EN
                limit_q     <= bus.cbc_mode ? 4'd1 : MAX_OUT;
`else
                limit_q     <= MAX_OUT;
`endif
            end else if (burst_issue) begin
                rd_addr_q   <= rd_addr_q + byte_step;
                wr_addr_q   <= wr_addr_q + byte_step;
                remaining_q <= remaining_q - burst_len;
            end

            // Issue and completion in the same cycle cancel out.
            if (accept) begin
                outstanding_q <= '0;
            end else if (burst_issue && !done_ok) begin
                outstanding_q <= outstanding_q + 4'd1;
            end else if (!burst_issue && done_ok) begin
                outstanding_q <= outstanding_q - 4'd1;
            end

            if (stray_done) begin
                err_q <= 1'b1;
            end else if (accept) begin
                err_q <= 1'b0;
            end

            if (launch) begin
                burst_act_q <= 1'b1;
            end else if (burst_issue) begin
                burst_act_q <= 1'b0;
            end

            if (launch) begin
                rd_vld_q <= 1'b1;
            end else if (rd_hs) begin
                rd_vld_q <= 1'b0;
            end

            if (launch) begin
                wr_vld_q <= 1'b1;
            end else if (wr_hs) begin
                wr_vld_q <= 1'b0;
            end

            // Remember which half of the pair has handshaken until the burst completes.
            if (burst_issue) begin
                rd_got_q <= 1'b0;
                wr_got_q <= 1'b0;
            end else begin
                if (rd_hs) begin
                    rd_got_q <= 1'b1;
                end
                if (wr_hs) begin
                    wr_got_q <= 1'b1;
                end
            end
        end
    end

    assign bus.ap_ready     = ap_ready_q;
    assign bus.ap_done      = done;
    assign bus.ap_idle      = idle;
    assign bus.rd_cmd_valid = rd_vld_q;
    assign bus.rd_cmd_addr  = rd_addr_q;
    assign bus.rd_cmd_len   = burst_len;
    assign bus.wr_cmd_valid = wr_vld_q;
    assign bus.wr_cmd_addr  = wr_addr_q;
    assign bus.wr_cmd_len   = burst_len;
    assign bus.err_unexp    = err_q;

endmodule

// File: tb/tb_krnl_cbc_ap_sequencer.sv
// Directed bench for krnl_cbc_ap_sequencer: burst splitting, handshakes, outstanding limit, reset.
// Build with KRNL_CBC_SEQ_SERIAL_EN defined to exercise the CBC serialisation path.
module tb_krnl_cbc_ap_sequencer;

    logic ACLK = 1'b0;
    logic ARESET = 1'b1;
    always #5 ACLK = ~ACLK;

    krnl_cbc_ap_sequencer_if bus();

    krnl_cbc_ap_sequencer #(
        .BURST_WORDS    (64),
        .WORD_BYTES     (16),
        .MAX_OUTSTANDING(4)
    ) dut (
        .ACLK  (ACLK),
        .ARESET(ARESET),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Handshake log, written only by this monitor.
    logic [63:0] rd_addr_log[$];
    logic [31:0] rd_len_log[$];
    logic [63:0] wr_addr_log[$];
    logic [31:0] wr_len_log[$];
    int rd_hs_cnt = 0;
    int wr_hs_cnt = 0;
    int rd_vld_cycles = 0;

    always @(posedge ACLK) begin
        if (!ARESET) begin
            if (bus.rd_cmd_valid) rd_vld_cycles++;
            if (bus.rd_cmd_valid && bus.rd_cmd_ready) begin
                rd_addr_log.push_back(bus.rd_cmd_addr);
                rd_len_log.push_back(bus.rd_cmd_len);
                rd_hs_cnt++;
            end
            if (bus.wr_cmd_valid && bus.wr_cmd_ready) begin
                wr_addr_log.push_back(bus.wr_cmd_addr);
                wr_len_log.push_back(bus.wr_cmd_len);
                wr_hs_cnt++;
            end
        end
    end

    int done_sent = 0;
    int done_req  = 0;
    bit auto_done = 1'b0;

    // One cycle; wr_done answers each write handshake one cycle later when auto_done is set.
    task automatic step();
        @(negedge ACLK);
        if (done_req > 0) begin
            bus.wr_done = 1'b1;
            done_req--;
            done_sent++;
        end else if (auto_done && (wr_hs_cnt > done_sent)) begin
            bus.wr_done = 1'b1;
            done_sent++;
        end else begin
            bus.wr_done = 1'b0;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic start_job(input logic [63:0] src, input logic [63:0] dst, input logic [31:0] words);
        bus.src_addr  = src;
        bus.dest_addr = dst;
        bus.words_num = words;
        bus.ap_start  = 1'b1;
        step();
        bus.ap_start  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (!bus.ap_done && k < budget) begin
            step();
            k++;
        end
        check(tag, bus.ap_done, 1'b1);
    endtask

    task automatic finish_job(input string tag);
        bus.ap_continue = 1'b1;
        step();
        bus.ap_continue = 1'b0;
        check(tag, {bus.ap_idle, bus.ap_done}, 2'b10);
    endtask

    logic [31:0] exp_len[4]  = '{32'd64, 32'd64, 32'd64, 32'd8};
    logic [63:0] exp_soff[4] = '{64'h0, 64'h400, 64'h800, 64'hC00};
    logic [63:0] exp_dst[4]  = '{64'hFFFF_FFFF_FFFF_F800, 64'hFFFF_FFFF_FFFF_FC00,
                                 64'h0, 64'h400};

    initial begin
        int idx;
        int widx;
        logic [63:0] src;

        bus.ap_start     = 1'b0;
        bus.ap_continue  = 1'b0;
        bus.cbc_mode     = 1'b0;
        bus.src_addr     = '0;
        bus.dest_addr    = '0;
        bus.words_num    = '0;
        bus.rd_cmd_ready = 1'b1;
        bus.wr_cmd_ready = 1'b1;
        bus.wr_done      = 1'b0;

        // Reset values
        #12;
        check("rst_flags", {bus.ap_idle, bus.ap_ready, bus.ap_done, bus.rd_cmd_valid,
                            bus.wr_cmd_valid, bus.err_unexp}, 6'b100000);
        check("rst_addr", bus.rd_cmd_addr, 64'h0);
        check("rst_len", bus.wr_cmd_len, 32'h0);
        @(negedge ACLK);
        ARESET = 1'b0;

        // Latency: single burst, ready high, prompt wr_done
        auto_done = 1'b1;
        start_job(64'h100, 64'h200, 32'd10);
        check("lat_ready", bus.ap_ready, 1'b1);
        check("lat_valid_e1", bus.rd_cmd_valid, 1'b0);
        step();
        check("lat_valid_e2", {bus.rd_cmd_valid, bus.wr_cmd_valid}, 2'b11);
        check("lat_ready_drop", bus.ap_ready, 1'b0);
        check("lat_len", bus.rd_cmd_len, 32'd10);
        steps(2);
        check("lat_done_e4", bus.ap_done, 1'b0);
        step();
        check("lat_done_e5", bus.ap_done, 1'b1);
        finish_job("lat_idle");

        // 200 words: 64,64,64,8 with destination wrapping through 2^64
        src = 64'h0000_0001_0000_0000;
        idx = rd_hs_cnt;
        widx = wr_hs_cnt;
        start_job(src, 64'hFFFF_FFFF_FFFF_F800, 32'd200);
        wait_done("w200_done", 60);
        check("w200_rd_count", rd_hs_cnt - idx, 4);
        check("w200_wr_count", wr_hs_cnt - widx, 4);
        for (int i = 0; i < 4; i++) begin
            if (rd_hs_cnt - idx > i) begin
                check($sformatf("w200_rd_len%0d", i), rd_len_log[idx + i], exp_len[i]);
                check($sformatf("w200_rd_addr%0d", i), rd_addr_log[idx + i], src + exp_soff[i]);
            end
            if (wr_hs_cnt - widx > i) begin
                check($sformatf("w200_wr_addr%0d", i), wr_addr_log[widx + i], exp_dst[i]);
                check($sformatf("w200_wr_len%0d", i), wr_len_log[widx + i], exp_len[i]);
            end
        end
        bus.ap_start = 1'b1;
        steps(3);
        check("done_hold", {bus.ap_done, bus.ap_ready, bus.ap_idle}, 3'b100);
        bus.ap_start = 1'b0;
        finish_job("w200_idle");

        // Zero-word job
        idx = rd_vld_cycles;
        start_job(64'h40, 64'h80, 32'd0);
        check("w0_ready", bus.ap_ready, 1'b1);
        check("w0_done", bus.ap_done, 1'b1);
        steps(3);
        check("w0_done_held", bus.ap_done, 1'b1);
        check("w0_no_valid", rd_vld_cycles - idx + int'(bus.rd_cmd_valid) + int'(bus.wr_cmd_valid), 0);
        finish_job("w0_idle");

        // Write channel stalled 5 cycles; read completes on its own
        idx = rd_hs_cnt;
        widx = wr_hs_cnt;
        start_job(64'h1000, 64'h2000, 32'd64);
        step();
        bus.wr_cmd_ready = 1'b0;
        step();
        check("stall_split", {bus.rd_cmd_valid, bus.wr_cmd_valid}, 2'b01);
        for (int i = 0; i < 4; i++) begin
            step();
            check("stall_wr_held", {bus.rd_cmd_valid, bus.wr_cmd_valid, bus.wr_cmd_addr},
                  {2'b01, 64'h2000});
        end
        bus.wr_cmd_ready = 1'b1;
        wait_done("stall_done", 20);
        check("stall_rd_count", rd_hs_cnt - idx, 1);
        check("stall_wr_count", wr_hs_cnt - widx, 1);
        check("stall_no_err", bus.err_unexp, 1'b0);
        finish_job("stall_idle");

        // Outstanding limit: 640 words, wr_done withheld
        auto_done = 1'b0;
        idx = rd_hs_cnt;
        widx = wr_hs_cnt;
        start_job(64'h4000, 64'h8000, 32'd640);
        steps(20);
        check("limit_four", rd_hs_cnt - idx, 4);
        check("limit_no_valid", {bus.rd_cmd_valid, bus.wr_cmd_valid}, 2'b00);
        done_req = 1;
        steps(6);
        check("limit_fifth", rd_hs_cnt - idx, 5);
        auto_done = 1'b1;
        wait_done("limit_done", 200);
        check("limit_total", wr_hs_cnt - widx, 10);
        if (wr_hs_cnt - widx == 10) check("limit_last_addr", wr_addr_log[widx + 9], 64'hA400);
        check("limit_no_err", bus.err_unexp, 1'b0);
        finish_job("limit_idle");

        // CBC request: serialised only when the option is built in
        auto_done = 1'b0;
        bus.cbc_mode = 1'b1;
        idx = rd_hs_cnt;
        start_job(64'h0, 64'h10000, 32'd128);
        steps(10);
`ifdef KRNL_CBC_SEQ_SERIAL_EN
        check("cbc_serial_one", rd_hs_cnt - idx, 1);
        done_req = 1;
        steps(5);
        check("cbc_serial_two", rd_hs_cnt - idx, 2);
`else
        check("cbc_ignored", rd_hs_cnt - idx, 2);
`endif
        bus.cbc_mode = 1'b0;
        auto_done = 1'b1;
        wait_done("cbc_done", 40);
        finish_job("cbc_idle");

        // Asynchronous reset mid-ISSUE, then a stray wr_done
        auto_done = 1'b0;
        start_job(64'h100000, 64'h200000, 32'd640);
        step();
        check("arst_pre_valid", bus.rd_cmd_valid, 1'b1);
        #2;
        ARESET = 1'b1;
        #1;
        check("arst_flags", {bus.ap_idle, bus.ap_ready, bus.ap_done, bus.rd_cmd_valid,
                             bus.wr_cmd_valid, bus.err_unexp}, 6'b100000);
        check("arst_addr", bus.rd_cmd_addr, 64'h0);
        check("arst_len", bus.rd_cmd_len, 32'h0);
        step();
        ARESET = 1'b0;
        done_sent = wr_hs_cnt;
        done_req = 1;
        step();
        step();
        check("err_stray", {bus.err_unexp, bus.ap_idle}, 2'b11);
        start_job(64'h0, 64'h0, 32'd0);
        check("err_clear", bus.err_unexp, 1'b0);
        finish_job("err_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
